// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder used once per cycle by the serial datapath.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and carry of a single bit position
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | ((a ^ b) & cin);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: accepts a, b, cin, adds LSB first over WIDTH cycles,
// then holds sum/cout/ovf until the consumer takes them.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
  logic               carry_q, carry_d;
  logic               c_msb_q, c_msb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               fa_s;
  logic               fa_co;

  full_adder_cell u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  // Next-state, datapath update and registered output values
  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    sum_sr_d    = sum_sr_q;
    carry_d     = carry_q;
    c_msb_d     = c_msb_q;
    cnt_d       = cnt_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    sum_d       = '0;
    cout_d      = 1'b0;
    ovf_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d   = a;
          b_sr_d   = b;
          sum_sr_d = '0;
          carry_d  = cin;
          c_msb_d  = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
        carry_d  = fa_co;
        cnt_d    = cnt_q + CNT_W'(1);
        // Last bit: the incoming carry is the carry into the MSB
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          c_msb_d = carry_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they align with it
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == DONE);
    if (state_d == DONE) begin
      sum_d  = sum_sr_d;
      cout_d = carry_d;
      ovf_d  = c_msb_d ^ carry_d;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sum_sr_q    <= '0;
      carry_q     <= 1'b0;
      c_msb_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      sum_sr_q    <= sum_sr_d;
      carry_q     <= carry_d;
      c_msb_q     <= c_msb_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one accepting edge, then scramble the inputs
  task automatic accept_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci);
    a        = ai;
    b        = bi;
    cin      = ci;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    cin      = 1'($urandom);
    check("acc_busy", 32'(busy), 32'd1);
    check("acc_in_ready", 32'(in_ready), 32'd0);
    check("acc_sum_zero", 32'(sum), 32'd0);
  endtask

  // Count edges from the accepting edge until out_valid rises
  task automatic wait_done(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(W));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic ci, input logic [W-1:0] es, input logic ec, input logic eo);
    accept_op(ai, bi, ci);
    wait_done(tag);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_sum"}, 32'(sum), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    run_op("v0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    run_op("vff_00_c1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    run_op("v7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("v80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op("vaa_55_c1", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
    run_op("vc0_c0", 8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0);

    // Hold in DONE with out_ready low while new requests are offered
    accept_op(8'h12, 8'h34, 1'b0);
    wait_done("hold");
    in_valid = 1'b1;
    a        = 8'hFF;
    b        = 8'hFF;
    cin      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(sum), 32'h46);
      check("hold_cout", 32'(cout), 32'd0);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_no_bypass", 32'(busy), 32'd0);
    in_valid = 1'b0;
    run_op("after_hold", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // Reset in the fourth RUN cycle discards the operation
    accept_op(8'hAA, 8'h55, 1'b1);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (out_valid === 1'b1) seen++;
      end
      check("midrst_no_pulse", 32'(seen), 32'd0);
    end
    run_op("post_rst", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

    // Back-to-back with both handshakes tied high
    begin
      int          prev_acc = -1;
      logic [W:0]  full;
      logic [W-1:0] av, bv;
      logic        eo;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int ai = 0; ai < 256; ai += 17) begin
        for (int bi = 0; bi < 256; bi += 17) begin
          for (int ci = 0; ci < 2; ci++) begin
            av  = W'(ai);
            bv  = W'(bi);
            a   = av;
            b   = bv;
            cin = 1'(ci);
            in_valid = 1'b1;
            check("b2b_in_ready", 32'(in_ready), 32'd1);
            step();
            if (prev_acc >= 0) check("b2b_period", 32'(cyc - prev_acc), 32'd10);
            prev_acc = cyc;
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            wait_done("b2b");
            full = {1'b0, av} + {1'b0, bv} + (W + 1)'(ci);
            eo   = (av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]);
            check("b2b_sum", 32'(sum), 32'(full[W-1:0]));
            check("b2b_cout", 32'(cout), 32'(full[W]));
            check("b2b_ovf", 32'(ovf), 32'(eo));
            step();
          end
        end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      step();
      check("b2b_end_idle", 32'(busy), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
